// File: rtl/clock_set_ctrl.sv
// Mode sequencer for the digital clock: button debounce, RUN/SET_HR/SET_MIN FSM,
// counter enables with auto-repeat, and blink strobes for the field being edited.
module clock_set_ctrl #(
    parameter int unsigned DEB_CYCLES   = 1_000_000,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000,
    parameter int unsigned BLINK_HALF   = 12_500_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic       hora,
    input  logic       min,
    input  logic       carry_sec,
    input  logic       carry_dmin,
    output logic       sec_run,
    output logic       sec_clr,
    output logic       enable_umin,
    output logic       enable_hr,
    output logic       blank_min,
    output logic       blank_hr,
    output logic [1:0] mode_st
);
    localparam int unsigned NB    = 3;
    localparam int unsigned B_SET = 0;
    localparam int unsigned B_HR  = 1;
    localparam int unsigned B_MIN = 2;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [NB-1:0]    sync1, sync2, acc, acc_n, acc_d, press;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_n, rep_limit;
    logic             rep_first, rep_first_n, armed, armed_n;
    logic [CNT_W-1:0] blink_cnt, blink_cnt_n;
    logic             phase, phase_n;
    logic             act_press, act_held, fire;
    logic             sec_run_n, sec_clr_n, enable_umin_n, enable_hr_n;
    logic             blank_min_n, blank_hr_n;

    // Per-button debounce: accept a new level after DEB_CYCLES consecutive mismatches.
    for (genvar b = 0; b < NB; b++) begin : g_deb
        logic [CNT_W-1:0] cnt_q;
        logic             acc_q;
        logic             flip;

        assign flip     = (sync2[b] != acc_q) && (cnt_q == DEB_LAST);
        assign acc_n[b] = acc_q ^ flip;
        assign acc[b]   = acc_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
                acc_q <= 1'b0;
            end else begin
                acc_q <= acc_n[b];
                if ((sync2[b] == acc_q) || flip) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign press   = acc & ~acc_d;
    assign mode_st = state;

    always_comb begin
        act_press     = 1'b0;
        act_held      = 1'b0;
        state_n       = state;
        armed_n       = armed;
        rep_cnt_n     = rep_cnt;
        rep_first_n   = rep_first;
        blink_cnt_n   = blink_cnt;
        phase_n       = phase;
        sec_clr_n     = 1'b0;
        enable_umin_n = 1'b0;
        enable_hr_n   = 1'b0;

        // Only the button that matches the current edit field counts.
        case (state)
            SET_HR: begin
                act_press = press[B_HR];
                act_held  = acc[B_HR];
            end
            SET_MIN: begin
                act_press = press[B_MIN];
                act_held  = acc[B_MIN];
            end
            default: ;
        endcase

        rep_limit = rep_first ? DELAY_LAST : RATE_LAST;
        fire      = armed & act_held & (rep_cnt == rep_limit);

        if (act_press) begin
            armed_n     = 1'b1;
            rep_cnt_n   = '0;
            rep_first_n = 1'b1;
        end else if (armed & act_held) begin
            if (fire) begin
                rep_cnt_n   = '0;
                rep_first_n = 1'b0;
            end else begin
                rep_cnt_n = rep_cnt + CNT_W'(1);
            end
        end else begin
            armed_n     = 1'b0;
            rep_cnt_n   = '0;
            rep_first_n = 1'b0;
        end

        if (press[B_SET]) begin
            case (state)
                RUN:     state_n = SET_HR;
                SET_HR:  state_n = SET_MIN;
                default: state_n = RUN;
            endcase
            armed_n     = 1'b0;
            rep_cnt_n   = '0;
            rep_first_n = 1'b0;
        end

        // Blink phase restarts low on every entry into an edit state.
        if ((state_n == RUN) || (state_n != state)) begin
            blink_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            phase_n     = ~phase;
        end else begin
            blink_cnt_n = blink_cnt + CNT_W'(1);
        end

        case (state)
            RUN: begin
                enable_umin_n = carry_sec;
                enable_hr_n   = carry_dmin;
            end
            SET_HR:  enable_hr_n = act_press | fire;
            SET_MIN: begin
                enable_umin_n = act_press | fire;
                sec_clr_n     = press[B_SET];
            end
            default: ;
        endcase

        sec_run_n   = (state_n == RUN);
        blank_hr_n  = (state_n == SET_HR) & phase_n & ~acc_n[B_HR];
        blank_min_n = (state_n == SET_MIN) & phase_n & ~acc_n[B_MIN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            sync1       <= '0;
            sync2       <= '0;
            acc_d       <= '0;
            armed       <= 1'b0;
            rep_cnt     <= '0;
            rep_first   <= 1'b0;
            blink_cnt   <= '0;
            phase       <= 1'b0;
            sec_run     <= 1'b1;
            sec_clr     <= 1'b0;
            enable_umin <= 1'b0;
            enable_hr   <= 1'b0;
            blank_min   <= 1'b0;
            blank_hr    <= 1'b0;
        end else begin
            state       <= state_n;
            sync1       <= {min, hora, set};
            sync2       <= sync1;
            acc_d       <= acc;
            armed       <= armed_n;
            rep_cnt     <= rep_cnt_n;
            rep_first   <= rep_first_n;
            blink_cnt   <= blink_cnt_n;
            phase       <= phase_n;
            sec_run     <= sec_run_n;
            sec_clr     <= sec_clr_n;
            enable_umin <= enable_umin_n;
            enable_hr   <= enable_hr_n;
            blank_min   <= blank_min_n;
            blank_hr    <= blank_hr_n;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_clock_set_ctrl;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 5;
    localparam int BH  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set = 1'b0, hora = 1'b0, min = 1'b0;
    logic       carry_sec = 1'b0, carry_dmin = 1'b0;
    logic       sec_run, sec_clr, enable_umin, enable_hr, blank_min, blank_hr;
    logic [1:0] mode_st;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    clock_set_ctrl #(
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_HALF(BH), .CNT_W(26)
    ) dut (
        .clk(clk), .rst(rst), .set(set), .hora(hora), .min(min),
        .carry_sec(carry_sec), .carry_dmin(carry_dmin),
        .sec_run(sec_run), .sec_clr(sec_clr), .enable_umin(enable_umin),
        .enable_hr(enable_hr), .blank_min(blank_min), .blank_hr(blank_hr),
        .mode_st(mode_st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: buttons as delayed levels with run-length acceptance,
    // repeats by hold age, blink by time since entering the edit state.
    bit m_s1[3], m_s2[3], m_acc[3], m_accp[3], m_raw[3], m_p[3];
    int m_run[3];
    int m_state, m_old, m_act, m_age, m_bage;
    bit m_track, m_rep, m_apress, m_phase;
    bit e_sec_run = 1'b1, e_sec_clr, e_umin, e_hr, e_bmin, e_bhr;
    int e_mode;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_accp[b] = 0; m_run[b] = 0;
            end
            m_state = 0; m_track = 0; m_age = 0; m_bage = 0;
            e_sec_run = 1; e_sec_clr = 0; e_umin = 0; e_hr = 0; e_bmin = 0; e_bhr = 0; e_mode = 0;
        end else begin
            m_raw[0] = set; m_raw[1] = hora; m_raw[2] = min;
            for (int b = 0; b < 3; b++) m_p[b] = m_acc[b] & ~m_accp[b];
            m_old = m_state;
            m_act = (m_old == 1) ? 1 : (m_old == 2) ? 2 : -1;
            m_rep = 0; m_apress = 0;
            if (m_act >= 0) begin
                m_apress = m_p[m_act];
                if (m_apress) begin
                    m_track = 1; m_age = 0;
                end else if (m_track && m_acc[m_act]) begin
                    m_age++;
                    m_rep = (m_age == RD) || (m_age > RD && (m_age - RD) % RR == 0);
                end else m_track = 0;
            end else m_track = 0;
            if (m_p[0]) begin
                m_state = (m_old + 1) % 3; m_track = 0; m_bage = 0;
            end else if (m_state != 0) m_bage++;
            else m_bage = 0;
            e_umin    = (m_old == 0) ? carry_sec  : (m_old == 2) ? (m_apress | m_rep) : 0;
            e_hr      = (m_old == 0) ? carry_dmin : (m_old == 1) ? (m_apress | m_rep) : 0;
            e_sec_clr = (m_old == 2) && m_p[0];
            for (int b = 0; b < 3; b++) begin
                m_accp[b] = m_acc[b];
                if (m_s2[b] != m_acc[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin m_acc[b] = ~m_acc[b]; m_run[b] = 0; end
                end else m_run[b] = 0;
                m_s2[b] = m_s1[b];
                m_s1[b] = m_raw[b];
            end
            m_phase   = ((m_bage / BH) % 2) == 1;
            e_sec_run = (m_state == 0);
            e_mode    = m_state;
            e_bhr     = (m_state == 1) && m_phase && !m_acc[1];
            e_bmin    = (m_state == 2) && m_phase && !m_acc[2];
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("sec_run", sec_run, e_sec_run);
            chk("sec_clr", sec_clr, e_sec_clr);
            chk("enable_umin", enable_umin, e_umin);
            chk("enable_hr", enable_hr, e_hr);
            chk("blank_min", blank_min, e_bmin);
            chk("blank_hr", blank_hr, e_bhr);
            chk("mode_st", mode_st, e_mode);
        end
    end

    int n_umin, n_hr, n_clr, clr_mode, clr_from, last_mode;

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        n_umin += int'(enable_umin);
        n_hr   += int'(enable_hr);
        if (sec_clr) begin
            n_clr++; clr_mode = int'(mode_st); clr_from = last_mode;
        end
        last_mode = int'(mode_st);
    endtask

    task automatic push(input int b, input int hold, input int gap);
        if (b == 0) set = 1; else if (b == 1) hora = 1; else min = 1;
        repeat (hold) tick();
        set = 0; hora = 0; min = 0;
        repeat (gap) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sec_run"}, sec_run, 1);
        chk({tag, "_sec_clr"}, sec_clr, 0);
        chk({tag, "_enable_umin"}, enable_umin, 0);
        chk({tag, "_enable_hr"}, enable_hr, 0);
        chk({tag, "_blank_min"}, blank_min, 0);
        chk({tag, "_blank_hr"}, blank_hr, 0);
        chk({tag, "_mode_st"}, mode_st, 0);
    endtask

    int lat, pulses[$], exp_off[6], cd[3], lvl[3];

    initial begin
        exp_off = '{0, 20, 25, 30, 35, 40};
        repeat (3) tick();
        cmp_en = 1;
        chk_reset_vals("reset");
        rst = 1;
        repeat (5) tick();

        // carry pass-through in RUN
        carry_sec = 1; tick(); carry_sec = 0;
        chk("carry_sec_next", enable_umin, 1);
        tick();
        chk("carry_sec_once", enable_umin, 0);
        repeat (10) tick();
        carry_dmin = 1; tick(); carry_dmin = 0;
        chk("carry_dmin_next", enable_hr, 1);
        tick();
        chk("carry_dmin_once", enable_hr, 0);

        // short set bounce is rejected, 10-cycle hold enters SET_HR after 7 cycles
        set = 1; repeat (3) tick(); set = 0;
        repeat (12) tick();
        chk("short_set_mode", mode_st, 0);
        set = 1; lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (lat == 0 && mode_st == 2'd1) lat = i;
            if (i == 10) set = 0;
            if (i == 10) chk("set_hr_sec_run", sec_run, 0);
            if (i == 7)  chk("blink_at_entry", blank_hr, 0);
            if (i == 14) chk("blink_low_end", blank_hr, 0);
            if (i == 15) chk("blink_first_high", blank_hr, 1);
            if (i == 22) chk("blink_high_end", blank_hr, 1);
            if (i == 23) chk("blink_second_low", blank_hr, 0);
            if (i == 31) chk("blink_second_high", blank_hr, 1);
            if (i == 31) chk("blink_min_quiet", blank_min, 0);
        end
        chk("set_latency", lat, 7);

        // hora held in SET_HR: initial pulse then auto-repeat, carries ignored
        n_umin = 0; hora = 1;
        for (int i = 1; i <= 65; i++) begin
            carry_sec = ($urandom_range(0, 2) == 0);
            tick();
            if (enable_hr) pulses.push_back(i);
            if (i == 30) chk("held_blank_hr", blank_hr, 0);
            if (i == 50) hora = 0;
        end
        carry_sec = 0;
        chk("repeat_count", pulses.size(), 7);
        chk("repeat_first_at", (pulses.size() > 0) ? pulses[0] : -1, 7);
        for (int j = 1; j < 6; j++)
            if (j < pulses.size()) chk("repeat_offset", pulses[j] - pulses[0], exp_off[j]);
        chk("set_hr_carry_ignored", n_umin, 0);

        // SET_MIN: three min presses, then back to RUN with one sec_clr
        push(0, 8, 8);
        chk("enter_set_min", mode_st, 2);
        n_umin = 0; n_hr = 0; n_clr = 0; clr_mode = -1; clr_from = -1;
        repeat (3) push(2, 8, 8);
        push(0, 8, 8);
        chk("min_press_count", n_umin, 3);
        chk("min_no_hr", n_hr, 0);
        chk("sec_clr_count", n_clr, 1);
        chk("sec_clr_mode", clr_mode, 0);
        chk("sec_clr_from", clr_from, 2);

        // reset in the middle of a min repeat
        push(0, 8, 8);
        push(0, 8, 8);
        chk("enter_set_min_again", mode_st, 2);
        min = 1;
        repeat (35) tick();
        rst = 0;
        #1;
        chk_reset_vals("async_reset");
        repeat (3) tick();
        rst = 1; n_umin = 0; n_hr = 0;
        repeat (60) tick();
        chk("post_reset_no_umin", n_umin, 0);
        chk("post_reset_mode", mode_st, 0);
        min = 0;
        repeat (10) tick();

        // randomized levels with bounces, carries and occasional resets
        for (int b = 0; b < 3; b++) begin cd[b] = 0; lvl[b] = 0; end
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (cd[b] == 0) begin
                    lvl[b] = ($urandom_range(0, 2) == 0) ? 1 : 0;
                    cd[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 45));
                end else cd[b]--;
            end
            set = lvl[0][0]; hora = lvl[1][0]; min = lvl[2][0];
            carry_sec  = ($urandom_range(0, 9) == 0);
            carry_dmin = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 999) == 0) rst = 0;
            else rst = 1;
            tick();
        end
        rst = 1; set = 0; hora = 0; min = 0; carry_sec = 0; carry_dmin = 0;
        repeat (5) tick();
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-keeping and time-setting sequencer for the configurable digital clock. Debounces the set/hora/min push buttons and runs a RUN / SET_HR / SET_MIN state machine. Drives the enables of the minute-units and hour counters and the freeze/clear controls of the seconds counter. Also produces display-blanking strobes so the field being edited blinks on the 7-segment digits.

## Interface
- DEB_CYCLES, 1_000_000 — cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz)
- REPEAT_DELAY, 25_000_000 — hold time before auto-repeat starts (0.5 s)
- REPEAT_RATE, 5_000_000 — auto-repeat period once repeating (0.1 s)
- BLINK_HALF, 12_500_000 — half-period of the edit-field blink (0.25 s)
- CNT_W, 26 — width of all internal timers; must hold the largest of the above
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- set  in  1  raw push button, high = pressed; cycles the mode
- hora  in  1  raw push button, high = pressed; increments hours in SET_HR
- min  in  1  raw push button, high = pressed; increments minutes in SET_MIN
- carry_sec  in  1  one-cycle pulse from the seconds counter on 59→0
- carry_dmin  in  1  one-cycle pulse from the tens-of-minutes counter on 5→0 (i.e. 59→00 min)
- sec_run  out  1  enable gate for the seconds counter (ANDed with the tic carry by the top level)
- sec_clr  out  1  one-cycle synchronous clear of the seconds counter
- enable_umin  out  1  one-cycle increment of the minute-units counter
- enable_hr  out  1  one-cycle increment of the hour counter
- blank_min  out  1  blank both minute digits
- blank_hr  out  1  blank both hour digits
- mode_st  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN

## Operation
- Each button passes through a 2-flop synchronizer and then a per-button debounce counter. The counter resets whenever the synchronized level equals the accepted level. When it reaches DEB_CYCLES-1, the accepted level flips and the counter clears. A rising edge of the accepted level produces a 1-cycle `press` pulse.
- FSM, advanced by set presses: RUN→SET_HR→SET_MIN→RUN. Reset state is RUN.
- RUN:
  - sec_run=1.
  - enable_umin = carry_sec.
  - enable_hr = carry_dmin.
  - hora and min presses are ignored.
- SET_HR:
  - sec_run=0; carry inputs are ignored.
  - A hora press gives one enable_hr pulse.
  - While hora stays accepted-high: after REPEAT_DELAY cycles, one enable_hr pulse; then one every REPEAT_RATE cycles.
- SET_MIN: same as SET_HR, but uses min and enable_umin. Minute rollover 59→00 does not increment hours, because enable_hr is gated to RUN.
- SET_MIN→RUN: sec_clr pulses once so the clock restarts at :00.
- Blink:
  - On entry to either SET state, the blink timer and phase clear to 0.
  - Phase toggles every BLINK_HALF cycles.
  - blank_hr = SET_HR & phase & ~hora_held.
  - blank_min = SET_MIN & phase & ~min_held.
  - In RUN, both are 0.
- Leaving a SET state clears the repeat timer. A button still held after entering a new state does not repeat until it is released and pressed again.
- Simultaneous events:
  - A carry in the same cycle as a set press is honored according to the state before the edge.
  - hora/min presses in the cycle the state changes are evaluated against the old state.
  - Pressing hora and min together: only the button matching the current state acts.

## Timing
- All outputs are registered. Reset (rst=0) forces asynchronously:
  - sec_run=1, sec_clr=0, enable_umin=0, enable_hr=0;
  - blank_min=0, blank_hr=0, mode_st=0;
  - all timers 0, accepted levels 0.
- Carry propagation: carry_sec at edge n → enable_umin high for exactly cycle n+1. carry_dmin behaves the same for enable_hr.
- Button latency: a raw edge at cycle n gives an accepted level at n+2+DEB_CYCLES. The press pulse, and any enable pulse or state change, appears 1 cycle later.
- A bounce shorter than DEB_CYCLES produces no press.
- Auto-repeat count: the first repeat pulse follows the initial press pulse by exactly REPEAT_DELAY cycles, then repeats every REPEAT_RATE cycles. Every enable pulse is exactly 1 cycle wide.
- Timer wrap: all timers saturate or clear at their terminal count and never wrap through 0 silently.
- Reset mid-operation (including mid-repeat or mid-blink) returns to RUN with no spurious pulse on release.

## Test plan
All scenarios use DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, BLINK_HALF=8.
- Reset, then carry_sec pulse at cycle 10 and carry_dmin pulse at cycle 30 → enable_umin at cycle 11 only, enable_hr at cycle 31 only; sec_run=1 and mode_st=0 throughout.
- set asserted for 3 cycles, then released → no state change. Held 10 cycles → mode_st=1 exactly 7 cycles after the rising edge; sec_run=0.
- In SET_HR, hold hora 50 cycles → enable_hr pulses at press+0, +20, +25, +30, +35, +40 (6 pulses total, plus ≤1 more depending on release); carry_sec pulses are ignored.
- In SET_MIN, press min 3 times, then press set → 3 enable_umin pulses, enable_hr never asserted, sec_clr one cycle wide in the same cycle mode_st returns to 0.
- In SET_HR with no buttons held → blank_hr toggles every 8 cycles starting low, blank_min stays 0. Holding hora forces blank_hr=0.
- Assert rst low mid-repeat in SET_MIN → all outputs immediately at reset values. After release, a still-held min produces no enable pulse.
